// File: rtl/main_fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : main_fsm_pkg
//  Description : Shared definitions for the multicycle ARM control FSM:
//                state encoding, opcode values, Funct bit positions and the
//                12-bit control-word layout produced by the output decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package main_fsm_pkg;

  // 4-bit state encoding, FETCH=0 ... UNKNOWN=10
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_e;

  // Instr[27:26] opcode classes; 2'b11 is illegal
  localparam logic [1:0] C_OP_DP  = 2'b00;
  localparam logic [1:0] C_OP_MEM = 2'b01;
  localparam logic [1:0] C_OP_BR  = 2'b10;

  // Bit positions inside Funct (Instr[25:20])
  localparam int C_FUNCT_I = 5;
  localparam int C_FUNCT_L = 0;

  // Control word. 'fetch' stands for IRWrite/NextPC, which are both
  // qualified with MemReady in the top level, so one bit covers both.
  typedef struct packed {
    logic       fetch;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       reg_we;
    logic       mem_we;
    logic       branch;
  } ctrl_word_t;

  // States whose exit into FETCH completes (retires) an instruction
  function automatic logic is_retire_state(input state_e s);
    return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_ALUWB) ||
           (s == S_BRANCH) || (s == S_UNKNOWN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/main_fsm_ctrl_outdec.sv
`default_nettype none
// ============================================================================
//  Module      : main_fsm_ctrl_outdec
//  Description : Purely combinational state -> control-word decoder.
//  Ports       : i_state [3:0]  current FSM state (state_e encoding)
//                o_ctrl  [11:0] control word (ctrl_word_t layout)
//  Revision    : 1.0 - initial release
// ============================================================================
module main_fsm_ctrl_outdec
  import main_fsm_pkg::*;
(
  input  logic [3:0]  i_state,
  output logic [11:0] o_ctrl
);

  ctrl_word_t w_cw;

  always_comb begin
    w_cw = '0;
    case (state_e'(i_state))
      S_FETCH: begin
        w_cw.fetch      = 1'b1;
        w_cw.alu_src_a  = 2'b01;
        w_cw.alu_src_b  = 2'b10;
        w_cw.result_src = 2'b10;
      end
      S_DECODE: begin
        w_cw.alu_src_a  = 2'b01;
        w_cw.alu_src_b  = 2'b10;
        w_cw.result_src = 2'b10;
      end
      S_MEMADR: begin
        w_cw.alu_src_a  = 2'b00;
        w_cw.alu_src_b  = 2'b01;
      end
      S_MEMRD: begin
        w_cw.adr_src    = 1'b1;
      end
      S_MEMWR: begin
        w_cw.adr_src    = 1'b1;
        w_cw.mem_we     = 1'b1;
      end
      S_MEMWB: begin
        w_cw.result_src = 2'b01;
        w_cw.reg_we     = 1'b1;
      end
      S_EXECUTER: begin
        w_cw.alu_src_b  = 2'b00;
        w_cw.alu_op     = 1'b1;
      end
      S_EXECUTEI: begin
        w_cw.alu_src_b  = 2'b01;
        w_cw.alu_op     = 1'b1;
      end
      S_ALUWB: begin
        w_cw.result_src = 2'b00;
        w_cw.reg_we     = 1'b1;
      end
      S_BRANCH: begin
        w_cw.alu_src_a  = 2'b10;
        w_cw.alu_src_b  = 2'b01;
        w_cw.result_src = 2'b10;
        w_cw.branch     = 1'b1;
      end
      default: ; // UNKNOWN and unused encodings drive nothing
    endcase
  end

  assign o_ctrl = w_cw;

endmodule
`default_nettype wire

// File: rtl/main_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : main_fsm
//  Description : Multicycle ARM control FSM (fetch/decode/execute/writeback).
//                Emits unconditional write requests and datapath mux selects
//                for the downstream condlogic block; stalls on MemReady.
//  Ports       : clk, reset (sync, active-high), Op[1:0], Funct[5:0],
//                MemReady -> IRWrite, AdrSrc, ALUSrcA[1:0], ALUSrcB[1:0],
//                ResultSrc[1:0], ALUOp, NextPC, RegWE, MemWE, Branch, Illegal,
//                CycCnt/InstCnt[CNT_W-1:0] (only with MAIN_FSM_PERF_EN).
//  Config      : `define MAIN_FSM_PERF_EN adds cycle / retired-instruction
//                counters; without it those ports and their logic are absent.
//  Revision    : 1.0 - initial release
// ============================================================================
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             MemReady,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic             ALUOp,
  output logic             NextPC,
  output logic             RegWE,
  output logic             MemWE,
  output logic             Branch,
  output logic             Illegal
`ifdef MAIN_FSM_PERF_EN
  ,
  output logic [CNT_W-1:0] CycCnt,
  output logic [CNT_W-1:0] InstCnt
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("main_fsm: CNT_W must be at least 1");
  end

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [11:0] w_ctrl_raw;
  ctrl_word_t w_cw;
  logic       w_unused_funct;

  // Only the I and L/S bits steer sequencing; the rest belong to the ALU decoder.
  assign w_unused_funct = ^Funct[4:1];

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:  if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          C_OP_MEM: state_d = S_MEMADR;
          C_OP_DP:  state_d = Funct[C_FUNCT_I] ? S_EXECUTEI : S_EXECUTER;
          C_OP_BR:  state_d = S_BRANCH;
          default: begin
            state_d   = S_UNKNOWN;
            illegal_d = 1'b1;   // sticky until reset, visible in UNKNOWN
          end
        endcase
      end
      S_MEMADR:   state_d = Funct[C_FUNCT_L] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    if (MemReady) state_d = S_MEMWB;
      S_MEMWR:    if (MemReady) state_d = S_FETCH;
      S_EXECUTER,
      S_EXECUTEI: state_d = S_ALUWB;
      default:    state_d = S_FETCH; // MEMWB, ALUWB, BRANCH, UNKNOWN, unused
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // ------------------------------------------------------------------ outputs
  main_fsm_ctrl_outdec u_outdec (
    .i_state (state_q),
    .o_ctrl  (w_ctrl_raw)
  );

  // Reset forces every output low regardless of the register contents, so a
  // reset landing mid-instruction cannot leak a write request.
  assign w_cw      = reset ? '0 : ctrl_word_t'(w_ctrl_raw);

  assign IRWrite   = w_cw.fetch & MemReady;
  assign NextPC    = w_cw.fetch & MemReady;
  assign AdrSrc    = w_cw.adr_src;
  assign ALUSrcA   = w_cw.alu_src_a;
  assign ALUSrcB   = w_cw.alu_src_b;
  assign ResultSrc = w_cw.result_src;
  assign ALUOp     = w_cw.alu_op;
  assign RegWE     = w_cw.reg_we;
  assign MemWE     = w_cw.mem_we;
  assign Branch    = w_cw.branch;
  assign Illegal   = illegal_q & ~reset;

`ifdef MAIN_FSM_PERF_EN
  // ------------------------------------------------------ performance counters
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] inst_q, inst_d;
  logic             w_retire;

  always_comb begin
    w_retire = (state_d == S_FETCH) && is_retire_state(state_q);
    cyc_d    = cyc_q + CNT_W'(1);
    inst_d   = w_retire ? inst_q + CNT_W'(1) : inst_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q  <= '0;
      inst_q <= '0;
    end else begin
      cyc_q  <= cyc_d;
      inst_q <= inst_d;
    end
  end

  assign CycCnt  = reset ? '0 : cyc_q;
  assign InstCnt = reset ? '0 : inst_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_main_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_main_fsm
//  Description : Directed self-checking bench for main_fsm. Each task runs one
//                instruction scenario cycle by cycle against hand-derived
//                control vectors. Counter checks run when MAIN_FSM_PERF_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_main_fsm;

  localparam int CNT_W = 32;

  // Observed vector layout:
  // {IRWrite, AdrSrc, ALUSrcA[1:0], ALUSrcB[1:0], ResultSrc[1:0],
  //  ALUOp, NextPC, RegWE, MemWE, Branch}
  localparam logic [13:0] V_ZERO = 14'b0;
  localparam logic [13:0] V_F1   = 14'b1_0_01_10_10_0_1_0_0_0; // FETCH, MemReady=1
  localparam logic [13:0] V_F0   = 14'b0_0_01_10_10_0_0_0_0_0; // FETCH, MemReady=0
  localparam logic [13:0] V_DEC  = 14'b0_0_01_10_10_0_0_0_0_0;
  localparam logic [13:0] V_MA   = 14'b0_0_00_01_00_0_0_0_0_0;
  localparam logic [13:0] V_MRD  = 14'b0_1_00_00_00_0_0_0_0_0;
  localparam logic [13:0] V_MWR  = 14'b0_1_00_00_00_0_0_0_1_0;
  localparam logic [13:0] V_MWB  = 14'b0_0_00_00_01_0_0_1_0_0;
  localparam logic [13:0] V_EXR  = 14'b0_0_00_00_00_1_0_0_0_0;
  localparam logic [13:0] V_EXI  = 14'b0_0_00_01_00_1_0_0_0_0;
  localparam logic [13:0] V_AWB  = 14'b0_0_00_00_00_0_0_1_0_0;
  localparam logic [13:0] V_BR   = 14'b0_0_10_01_10_0_0_0_0_1;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic       mem_ready;

  logic       ir_write, adr_src, alu_op, next_pc, reg_we, mem_we, branch, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [13:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MAIN_FSM_PERF_EN
  logic [CNT_W-1:0] cyc_cnt, inst_cnt;
`endif

  main_fsm #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (op),
    .Funct     (funct),
    .MemReady  (mem_ready),
    .IRWrite   (ir_write),
    .AdrSrc    (adr_src),
    .ALUSrcA   (alu_src_a),
    .ALUSrcB   (alu_src_b),
    .ResultSrc (result_src),
    .ALUOp     (alu_op),
    .NextPC    (next_pc),
    .RegWE     (reg_we),
    .MemWE     (mem_we),
    .Branch    (branch),
    .Illegal   (illegal)
`ifdef MAIN_FSM_PERF_EN
    ,
    .CycCnt    (cyc_cnt),
    .InstCnt   (inst_cnt)
`endif
  );

  assign obs = {ir_write, adr_src, alu_src_a, alu_src_b, result_src,
                alu_op, next_pc, reg_we, mem_we, branch};

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.

  task automatic test_reset();
    reset = 1'b1; op = 2'b00; funct = 6'b0; mem_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    n_checks++;
    if (obs !== V_ZERO) begin
      n_fail++; $display("FAIL reset_outputs: ctrl=%b expected %b", obs, V_ZERO);
    end
    n_checks++;
    if (illegal !== 1'b0) begin
      n_fail++; $display("FAIL reset_illegal: got %b expected 0", illegal);
    end
    mem_ready = 1'b1; #1;   // IRWrite/NextPC must stay low under reset
    n_checks++;
    if (obs !== V_ZERO) begin
      n_fail++; $display("FAIL reset_memready: ctrl=%b expected %b", obs, V_ZERO);
    end
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0; #1;
    n_checks++;
    if (obs !== V_F0) begin
      n_fail++; $display("FAIL reset_release_fetch: ctrl=%b expected %b", obs, V_F0);
    end
    @(negedge clk);
  endtask

  task automatic test_add_reg();
    logic [13:0] exp_v [5] = '{V_F1, V_DEC, V_EXR, V_AWB, V_F0};
    logic        mr_v  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    op = 2'b00; funct = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr_v[i]; #1;
      n_checks++;
      if (obs !== exp_v[i]) begin
        n_fail++; $display("FAIL add_reg cycle %0d: ctrl=%b expected %b", i, obs, exp_v[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_dp_imm();
    logic [13:0] exp_v [5] = '{V_F1, V_DEC, V_EXI, V_AWB, V_F0};
    logic        mr_v  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    op = 2'b00; funct = 6'b101000;
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr_v[i]; #1;
      n_checks++;
      if (obs !== exp_v[i]) begin
        n_fail++; $display("FAIL dp_imm cycle %0d: ctrl=%b expected %b", i, obs, exp_v[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ldr_stall();
    logic [13:0] exp_v [9] = '{V_F1, V_DEC, V_MA, V_MRD, V_MRD, V_MRD, V_MRD, V_MWB, V_F0};
    logic        mr_v  [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    op = 2'b01; funct = 6'b000001;
    for (int i = 0; i < 9; i++) begin
      mem_ready = mr_v[i]; #1;
      n_checks++;
      if (obs !== exp_v[i]) begin
        n_fail++; $display("FAIL ldr_stall cycle %0d: ctrl=%b expected %b", i, obs, exp_v[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_str_stall();
    logic [13:0] exp_v [7] = '{V_F1, V_DEC, V_MA, V_MWR, V_MWR, V_MWR, V_F0};
    logic        mr_v  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    op = 2'b01; funct = 6'b000000;
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr_v[i]; #1;
      n_checks++;
      if (obs !== exp_v[i]) begin
        n_fail++; $display("FAIL str_stall cycle %0d: ctrl=%b expected %b", i, obs, exp_v[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    logic [13:0] exp_v [4] = '{V_F1, V_DEC, V_BR, V_F0};
    logic        mr_v  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    op = 2'b10; funct = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      mem_ready = mr_v[i]; #1;
      n_checks++;
      if (obs !== exp_v[i]) begin
        n_fail++; $display("FAIL branch cycle %0d: ctrl=%b expected %b", i, obs, exp_v[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    // Op=11, then an ADD that must still sequence with Illegal held high
    logic [13:0] exp_v [8] = '{V_F1, V_DEC, V_ZERO, V_F1, V_DEC, V_EXR, V_AWB, V_F0};
    logic        mr_v  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        ill_v [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    funct = 6'b001000;
    for (int i = 0; i < 8; i++) begin
      op = (i < 3) ? 2'b11 : 2'b00;
      mem_ready = mr_v[i]; #1;
      n_checks++;
      if (obs !== exp_v[i]) begin
        n_fail++; $display("FAIL illegal cycle %0d: ctrl=%b expected %b", i, obs, exp_v[i]);
      end
      n_checks++;
      if (illegal !== ill_v[i]) begin
        n_fail++; $display("FAIL illegal_flag cycle %0d: got %b expected %b", i, illegal, ill_v[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_instr();
    // Illegal is still set from the previous task; reset must clear it.
    logic [13:0] exp_v [4] = '{V_F1, V_DEC, V_MA, V_MWR};
    op = 2'b01; funct = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i < 3); #1;
      n_checks++;
      if (obs !== exp_v[i]) begin
        n_fail++; $display("FAIL reset_mid cycle %0d: ctrl=%b expected %b", i, obs, exp_v[i]);
      end
      @(negedge clk);
    end
    reset = 1'b1; mem_ready = 1'b0; #1;  // state still MEMWR
    n_checks++;
    if (obs !== V_ZERO) begin
      n_fail++; $display("FAIL reset_mid_in_memwr: ctrl=%b expected %b", obs, V_ZERO);
    end
    @(negedge clk);
    reset = 1'b0; #1;
    n_checks++;
    if (obs !== V_F0) begin
      n_fail++; $display("FAIL reset_mid_next_fetch: ctrl=%b expected %b", obs, V_F0);
    end
    n_checks++;
    if (illegal !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_illegal: got %b expected 0", illegal);
    end
    @(negedge clk);
    mem_ready = 1'b1; #1;
    n_checks++;
    if (obs !== V_F1) begin
      n_fail++; $display("FAIL reset_mid_fetch_resume: ctrl=%b expected %b", obs, V_F1);
    end
    @(negedge clk);
    mem_ready = 1'b0; #1;
    n_checks++;
    if (obs !== V_DEC) begin
      n_fail++; $display("FAIL reset_mid_decode: ctrl=%b expected %b", obs, V_DEC);
    end
    @(negedge clk);  // DECODE -> MEMADR (Op=01)
    @(negedge clk);  // MEMADR -> MEMWR, stalled with MemReady=0
    mem_ready = 1'b1;
    @(negedge clk);  // MEMWR -> FETCH
    mem_ready = 1'b0;
  endtask

`ifdef MAIN_FSM_PERF_EN
  task automatic test_perf_counters();
    // ADD, LDR, STR, B, ILL, ADDI, LDR, STR, B, ADD: 4+5+4+3+3+4+5+4+3+4 = 39
    logic [1:0] op_v  [10] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11,
                               2'b00, 2'b01, 2'b01, 2'b10, 2'b00};
    logic [5:0] fn_v  [10] = '{6'b001000, 6'b000001, 6'b000000, 6'b000000, 6'b000000,
                               6'b101000, 6'b000001, 6'b000000, 6'b000000, 6'b001000};
    int         lat_v [10] = '{4, 5, 4, 3, 3, 4, 5, 4, 3, 4};
    reset = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0; #1;
    n_checks++;
    if (cyc_cnt !== '0 || inst_cnt !== '0) begin
      n_fail++; $display("FAIL perf_start: cyc=%0d inst=%0d expected 0 0", cyc_cnt, inst_cnt);
    end
    for (int i = 0; i < 10; i++) begin
      op = op_v[i]; funct = fn_v[i];
      repeat (lat_v[i]) @(negedge clk);
      if (i == 0) begin
        #1;
        n_checks++;
        if (cyc_cnt !== 32'd4 || inst_cnt !== 32'd1) begin
          n_fail++; $display("FAIL perf_first: cyc=%0d inst=%0d expected 4 1", cyc_cnt, inst_cnt);
        end
      end
    end
    mem_ready = 1'b0; #1;
    n_checks++;
    if (inst_cnt !== 32'd10) begin
      n_fail++; $display("FAIL perf_inst_cnt: got %0d expected 10", inst_cnt);
    end
    n_checks++;
    if (cyc_cnt !== 32'd39) begin
      n_fail++; $display("FAIL perf_cyc_cnt: got %0d expected 39", cyc_cnt);
    end
    n_checks++;
    if (obs !== V_F0) begin
      n_fail++; $display("FAIL perf_end_fetch: ctrl=%b expected %b", obs, V_F0);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_add_reg();
    test_dp_imm();
    test_ldr_stall();
    test_str_stall();
    test_branch();
    test_illegal();
    test_reset_mid_instr();
`ifdef MAIN_FSM_PERF_EN
    test_perf_counters();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
